// File: rtl/flag_scheduler_pkg.sv
// Shared types and helpers for the flag scheduler: FSM state encoding and index-width sizing.
package flag_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width needed to index n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/flag_scheduler_pick.sv
// Round-robin search: first pending index at or above ptr, wrapping to 0.
module flag_scheduler_pick #(
  parameter int NUM_FLAGS = 5,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_FLAGS-1:0] pending,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic                 found;
  logic [NUM_FLAGS-1:0] shifted;
  int                   cand;

  always_comb begin
    idx     = '0;
    found   = 1'b0;
    shifted = '0;
    cand    = 0;
    for (int k = 0; k < NUM_FLAGS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_FLAGS) cand = cand - NUM_FLAGS;
      shifted = pending >> cand;
      if (!found && shifted[0]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/flag_scheduler.sv
// Sticky flag collector with round-robin offer/handshake FSM.
// Optional offer timeout is built when FLAG_SCHEDULER_TIMEOUT_EN is defined.
module flag_scheduler
  import flag_scheduler_pkg::*;
#(
  parameter int NUM_FLAGS      = 5,
  parameter int INCLUDE_FLAGS  = 1,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = idx_width(NUM_FLAGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cg,
  input  logic [NUM_FLAGS-1:0] i_set,
  input  logic                 i_clr,
  output logic [NUM_FLAGS-1:0] o_pending,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_timeout
);

  if (NUM_FLAGS < 1) begin : g_bad_num_flags
    $error("flag_scheduler: NUM_FLAGS must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("flag_scheduler: TIMEOUT_CYCLES must be >= 1");
  end

  if (INCLUDE_FLAGS != 0) begin : g_full
    state_t               state, state_nx;
    logic [NUM_FLAGS-1:0] pending, ack;
    logic [IDX_W-1:0]     ptr, idx, pick_idx, idx_inc;
    logic                 pick_any, valid, hshk, expire, tout;

    flag_scheduler_pick #(.NUM_FLAGS(NUM_FLAGS), .IDX_W(IDX_W)) u_pick (
      .pending (pending),
      .ptr     (ptr),
      .idx     (pick_idx),
      .any     (pick_any)
    );

    assign hshk    = valid & i_ready;
    assign ack     = hshk ? (NUM_FLAGS'(1) << idx) : '0;
    assign idx_inc = (int'(idx) == NUM_FLAGS - 1) ? '0 : idx + IDX_W'(1);

`ifdef FLAG_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tcnt;

    // Counter sits at zero outside OFFER, so it is cleared on every entry.
    assign expire = (state == OFFER) && !hshk && !i_clr &&
                    (int'(tcnt) + 1 >= TIMEOUT_CYCLES);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     tcnt <= '0;
      else if (i_cg) tcnt <= (state == OFFER) ? tcnt + CNT_W'(1) : '0;
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     state <= IDLE;
      else if (i_cg) state <= state_nx;
    end

    always_comb begin
      state_nx = state;
      case (state)
        IDLE:    if (pick_any && !i_clr) state_nx = OFFER;
        OFFER:   if (i_clr) state_nx = IDLE;
                 else if (hshk || expire) state_nx = GAP;
        GAP:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    always_comb begin
      valid = (state == OFFER);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        pending <= '0;
        ptr     <= '0;
        idx     <= '0;
        tout    <= 1'b0;
      end else if (i_cg) begin
        pending <= i_set | (pending & ~ack & {NUM_FLAGS{~i_clr}});
        tout    <= expire;
        if (state == IDLE && state_nx == OFFER) idx <= pick_idx;
        // A clear withdraws the offer without moving the round-robin pointer.
        if (state == OFFER && !i_clr && (hshk || expire)) ptr <= idx_inc;
      end
    end

    assign o_pending = pending;
    assign o_valid   = valid;
    assign o_idx     = idx;
    assign o_timeout = tout;
  end else begin : g_off
    logic unused_in;
    assign unused_in = ^{i_clk, i_rst, i_cg, i_set, i_clr, i_ready};
    assign o_pending = '0;
    assign o_valid   = 1'b0;
    assign o_idx     = '0;
    assign o_timeout = 1'b0;
  end

endmodule

// File: tb/tb_flag_scheduler.sv
// Directed bench for flag_scheduler: main 5-flag instance plus 1-flag and disabled instances.
module tb_flag_scheduler;

  logic       clk, rst, cg, clr, ready;
  logic [4:0] set, pending;
  logic       valid, timeout;
  logic [2:0] idx;

  logic [0:0] set_one, pending_one, idx_one;
  logic       ready_one, valid_one, timeout_one;

  logic [4:0] set_off, pending_off;
  logic [2:0] idx_off;
  logic       ready_off, valid_off, timeout_off;

  int n_chk  = 0;
  int n_pass = 0;

  flag_scheduler #(.NUM_FLAGS(5), .INCLUDE_FLAGS(1), .TIMEOUT_CYCLES(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_set(set), .i_clr(clr),
    .o_pending(pending), .o_valid(valid), .i_ready(ready), .o_idx(idx),
    .o_timeout(timeout)
  );

  flag_scheduler #(.NUM_FLAGS(1), .INCLUDE_FLAGS(1), .TIMEOUT_CYCLES(3)) u_one (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_set(set_one), .i_clr(clr),
    .o_pending(pending_one), .o_valid(valid_one), .i_ready(ready_one), .o_idx(idx_one),
    .o_timeout(timeout_one)
  );

  flag_scheduler #(.NUM_FLAGS(5), .INCLUDE_FLAGS(0), .TIMEOUT_CYCLES(3)) u_off (
    .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_set(set_off), .i_clr(clr),
    .o_pending(pending_off), .o_valid(valid_off), .i_ready(ready_off), .o_idx(idx_off),
    .o_timeout(timeout_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; clr = 1'b0; ready = 1'b0; set = '0;
    set_one = '0; ready_one = 1'b1; set_off = '0; ready_off = 1'b1;
    step(); step();
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_valid",   32'(valid),   32'd0);
    chk("rst_idx",     32'(idx),     32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_one",     32'({pending_one, valid_one, idx_one, timeout_one}), 32'd0);
    chk("rst_off",     32'({pending_off, valid_off, idx_off, timeout_off}), 32'd0);
    rst = 1'b0;
    step();

    // Two flags granted in index order with ready held high
    ready = 1'b1; set = 5'b10100; set_one = 1'b1;
    step();
    set = '0; set_one = '0;
    chk("t1_pending_set", 32'(pending), 32'h14);
    chk("t1_valid_lat1",  32'(valid),   32'd0);
    chk("one_pending",    32'(pending_one), 32'd1);
    step();
    chk("t1_valid_a", 32'(valid), 32'd1);
    chk("t1_idx_a",   32'(idx),   32'd2);
    chk("one_valid",  32'(valid_one), 32'd1);
    chk("one_idx",    32'(idx_one),   32'd0);
    step();
    chk("t1_gap_valid",   32'(valid),   32'd0);
    chk("t1_pending_mid", 32'(pending), 32'h10);
    chk("one_done",       32'({pending_one, valid_one}), 32'd0);
    wait_valid("t1_wait_b");
    chk("t1_idx_b", 32'(idx), 32'd4);
    step();
    chk("t1_pending_end", 32'(pending), 32'd0);
    chk("t1_valid_end",   32'(valid),   32'd0);
    ready = 1'b0;
    step();

    // Grant flag 3 (ptr -> 4), then pending 00011 wraps to 0 then 1
    ready = 1'b1; set = 5'b01000;
    step();
    set = '0;
    wait_valid("t2_wait3");
    chk("t2_idx3", 32'(idx), 32'd3);
    step();
    ready = 1'b0; set = 5'b00011;
    step();
    set = '0;
    step();
    chk("t2_valid_wrap", 32'(valid), 32'd1);
    chk("t2_idx_wrap",   32'(idx),   32'd0);
    ready = 1'b1;
    step();
    wait_valid("t2_wait1");
    chk("t2_idx1", 32'(idx), 32'd1);
    step();
    chk("t2_pending_end", 32'(pending), 32'd0);
    ready = 1'b0;

    // Set on the same edge as the ack keeps the flag pending
    set = 5'b00010;
    step();
    set = '0;
    step();
    chk("t3_valid", 32'(valid), 32'd1);
    chk("t3_idx",   32'(idx),   32'd1);
    ready = 1'b1; set = 5'b00010;
    step();
    set = '0;
    chk("t3_pending_kept", 32'(pending), 32'h02);
    chk("t3_gap_valid",    32'(valid),   32'd0);
    wait_valid("t3_wait_reoffer");
    chk("t3_idx_reoffer", 32'(idx), 32'd1);
    step();
    chk("t3_pending_end", 32'(pending), 32'd0);
    ready = 1'b0;

    // Clear aborts an offer and leaves ptr (2) alone
    set = 5'b01001;
    step();
    set = '0;
    step();
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_idx",   32'(idx),   32'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_valid",   32'(valid),   32'd0);
    chk("t4_clr_pending", 32'(pending), 32'd0);
    set = 5'b00101;
    step();
    set = '0;
    step();
    chk("t4_ptr_kept_idx", 32'(idx), 32'd2);
    clr = 1'b1; set = 5'b00001;
    step();
    clr = 1'b0; set = '0;
    chk("t4_set_over_clr", 32'(pending), 32'h01);
    chk("t4_clr_valid2",   32'(valid),   32'd0);
    step();
    chk("t5_valid_rise", 32'(valid), 32'd1);
    chk("t5_idx",        32'(idx),   32'd0);

`ifdef FLAG_SCHEDULER_TIMEOUT_EN
    step();
    chk("t5_to_c1", 32'({valid, timeout}), 32'h2);
    step();
    chk("t5_to_c2", 32'({valid, timeout}), 32'h2);
    step();
    chk("t5_to_pulse",   32'(timeout), 32'd1);
    chk("t5_to_valid",   32'(valid),   32'd0);
    chk("t5_to_pending", 32'(pending), 32'h01);
    step();
    chk("t5_to_end", 32'(timeout), 32'd0);
    wait_valid("t5_reoffer");
    chk("t5_reoffer_idx", 32'(idx), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_hold", 32'({valid, timeout}), 32'h2);
    end
    chk("t5_hold_idx", 32'(idx), 32'd0);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Clock gate freezes everything
    cg = 1'b0; set = 5'b00100;
    step();
    chk("t6_cg_set", 32'(pending), 32'd0);
    cg = 1'b1;
    step();
    set = '0; cg = 1'b0;
    chk("t6_set", 32'(pending), 32'h04);
    step(); step(); step();
    chk("t6_cg_idle", 32'(valid), 32'd0);
    cg = 1'b1;
    step();
    chk("t6_valid", 32'(valid), 32'd1);
    chk("t6_idx",   32'(idx),   32'd2);
    ready = 1'b1; cg = 1'b0;
    step();
    chk("t6_cg_hold", 32'({pending, valid}), 32'({5'b00100, 1'b1}));
    cg = 1'b1;
    step();
    chk("t6_ack", 32'({pending, valid}), 32'd0);
    ready = 1'b0;

    // Reset mid-offer drops valid without waiting for an edge
    set = 5'b00001;
    step();
    set = '0;
    step();
    chk("t7_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("t7_async_valid", 32'(valid), 32'd0);
    step();
    chk("t7_rst_state", 32'({pending, idx}), 32'd0);
    rst = 1'b0; ready = 1'b0;

    // Disabled instance stays silent under random sets
    for (int i = 0; i < 10; i++) begin
      set_off = 5'($urandom);
      step();
      chk("off_zero", 32'({pending_off, valid_off, idx_off, timeout_off}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
